// File: rtl/cpu5_mcctrl.sv
// cpu5_mcctrl: multicycle main controller for the cpu5 single-ALU datapath.
// Sequences one instruction at a time through fetch/decode/execute/memory/writeback
// and handshakes with instruction and data memories of arbitrary latency.
// Optional build macro CPU5_MCCTRL_ILLEGAL_TRAP_EN adds an 'illegal' output and a
// HALT state entered on unknown opcodes or unmapped R-type funct codes.
module cpu5_mcctrl #(
  parameter int unsigned ALUCW = 3,
  parameter int unsigned XLEN  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  instr,
  input  logic             zero,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             instr_we,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             pcwrite,
  output logic             memtoreg,
  output logic             pcsrc,
  output logic             alusrc,
  output logic             regdst,
  output logic             regwrite,
  output logic             jump,
  output logic [ALUCW-1:0] alucontrol,
`ifdef CPU5_MCCTRL_ILLEGAL_TRAP_EN
  output logic             illegal,
`endif
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StExecR    = 4'd3,
    StWbR      = 4'd4,
    StExecI    = 4'd5,
    StWbI      = 4'd6,
    StExecAddr = 4'd7,
    StMem      = 4'd8,
    StWbL      = 4'd9,
    StBranch   = 4'd10,
    StJump     = 4'd11,
    StNop      = 4'd12,
    StHalt     = 4'd13
  } state_e;

  localparam logic [ALUCW-1:0] AluAnd = ALUCW'(3'b000);
  localparam logic [ALUCW-1:0] AluOr  = ALUCW'(3'b001);
  localparam logic [ALUCW-1:0] AluAdd = ALUCW'(3'b010);
  localparam logic [ALUCW-1:0] AluSub = ALUCW'(3'b110);
  localparam logic [ALUCW-1:0] AluSlt = ALUCW'(3'b111);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  state_e state_q, state_d;

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_instr_bits;

  assign op    = instr[XLEN-1:XLEN-6];
  assign funct = instr[5:0];
  // Register fields are consumed by the datapath, not here.
  assign unused_instr_bits = ^instr[XLEN-7:6];

  // R-type funct to ALU operation; unmapped codes fall back to ADD.
  function automatic logic [ALUCW-1:0] funct_alu(input logic [5:0] f);
    logic [ALUCW-1:0] a;
    a = AluAdd;
    case (f)
      6'b100000: a = AluAdd;
      6'b100010: a = AluSub;
      6'b100100: a = AluAnd;
      6'b100101: a = AluOr;
      6'b101010: a = AluSlt;
      default:   a = AluAdd;
    endcase
    return a;
  endfunction

`ifdef CPU5_MCCTRL_ILLEGAL_TRAP_EN
  function automatic logic funct_legal(input logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b101010);
  endfunction

  assign illegal = (state_q == StHalt);
`endif

  assign state = state_q;

  // State register; reset forces IDLE immediately so requests drop at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore-style output decode (acks and zero only in listed states).
  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    instr_we   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pcwrite    = 1'b0;
    memtoreg   = 1'b0;
    pcsrc      = 1'b0;
    alusrc     = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    jump       = 1'b0;
    alucontrol = AluAdd;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_we = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        case (op)
          OpRtype: begin
`ifdef CPU5_MCCTRL_ILLEGAL_TRAP_EN
            state_d = funct_legal(funct) ? StExecR : StHalt;
`else
            state_d = StExecR;
`endif
          end
          OpLw, OpSw: state_d = StExecAddr;
          OpAddi:     state_d = StExecI;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
`ifdef CPU5_MCCTRL_ILLEGAL_TRAP_EN
          default:    state_d = StHalt;
`else
          default:    state_d = StNop;
`endif
        endcase
      end
      StExecR: begin
        alucontrol = funct_alu(funct);
        state_d    = StWbR;
      end
      StWbR: begin
        alucontrol = funct_alu(funct);
        regdst     = 1'b1;
        regwrite   = 1'b1;
        pcwrite    = 1'b1;
        state_d    = StFetch;
      end
      StExecI: begin
        alusrc  = 1'b1;
        state_d = StWbI;
      end
      StWbI: begin
        alusrc   = 1'b1;
        regwrite = 1'b1;
        pcwrite  = 1'b1;
        state_d  = StFetch;
      end
      StExecAddr: begin
        alusrc  = 1'b1;
        state_d = StMem;
      end
      StMem: begin
        alusrc   = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = (op == OpSw);
        if (dmem_ack) begin
          if (op == OpSw) begin
            // Stores retire on the ack cycle; there is no writeback.
            pcwrite = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWbL;
          end
        end
      end
      StWbL: begin
        alusrc   = 1'b1;
        memtoreg = 1'b1;
        regwrite = 1'b1;
        pcwrite  = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        alucontrol = AluSub;
        pcsrc      = zero;
        pcwrite    = 1'b1;
        state_d    = StFetch;
      end
      StJump: begin
        jump    = 1'b1;
        pcwrite = 1'b1;
        state_d = StFetch;
      end
      StNop: begin
        pcwrite = 1'b1;
        state_d = StFetch;
      end
      // Only a reset leaves HALT.
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: doc/cpu5_mcctrl.md
Name: cpu5_mcctrl

Overview:
Multicycle main controller FSM that sequences the cpu5 single-ALU datapath one instruction at a time. Decodes the MIPS-style opcode/funct from the latched instruction and drives the datapath selects: memtoreg, pcsrc, alusrc, regdst, regwrite, jump and alucontrol. Adds a PC write enable and a request/acknowledge handshake to instruction and data memory, so memories may take any number of cycles.

Parameters:
ALUCW, 3, alucontrol width; must equal CPU5_ALU_CONTROL_SIZE
XLEN, 32, instruction width; only bits [31:26] (op) and [5:0] (funct) are decoded

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
instr  input  XLEN  current instruction from datapath instruction register
zero  input  1  ALU zero flag from datapath
imem_req  output  1  instruction fetch request
imem_ack  input  1  fetch complete; instr valid next cycle
instr_we  output  1  one-cycle pulse: datapath latches fetched instruction
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (sw), valid with dmem_req
dmem_ack  input  1  data access complete
pcwrite  output  1  PC register enable, one pulse per retired instruction
memtoreg, pcsrc, alusrc, regdst, regwrite, jump  output  1 each  datapath selects
alucontrol  output  ALUCW  ALU operation
state  output  4  current FSM state (debug)

Behaviour:
- Moore outputs decoded from state (plus zero, instr in listed states). Defaults: all 1-bit outputs 0, alucontrol = ADD.
- Reset: state = IDLE, all outputs at defaults, asynchronously. Reset mid-access drops imem_req/dmem_req immediately; no partial retire.
- ALU encoding: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
- Funct map (R-type): 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; any other funct -> ADD.
- States and transitions:
- IDLE(0): -> FETCH unconditionally.
- FETCH(1): imem_req=1; hold until imem_ack; on ack instr_we=1 same cycle, -> DECODE.
- DECODE(2): op 000000 -> EXEC_R; 100011 (lw) / 101011 (sw) -> EXEC_ADDR; 001000 (addi) -> EXEC_I; 000100 (beq) -> BRANCH; 000010 (j) -> JUMP; other -> NOP (see optional feature).
- EXEC_R(3): alusrc=0, alucontrol=funct map -> WB_R.
- WB_R(4): as EXEC_R plus regdst=1, regwrite=1, pcwrite=1 -> FETCH.
- EXEC_I(5): alusrc=1, ADD -> WB_I.
- WB_I(6): alusrc=1, ADD, regdst=0, regwrite=1, pcwrite=1 -> FETCH.
- EXEC_ADDR(7): alusrc=1, ADD -> MEM.
- MEM(8): alusrc=1, ADD, dmem_req=1, dmem_we=(op==sw); hold until dmem_ack. sw: pcwrite=1 on ack cycle, -> FETCH. lw: -> WB_L.
- WB_L(9): alusrc=1, memtoreg=1, regdst=0, regwrite=1, pcwrite=1 -> FETCH.
- BRANCH(10): alusrc=0, SUB, pcsrc=zero, pcwrite=1 -> FETCH.
- JUMP(11): jump=1, pcwrite=1 -> FETCH.
- NOP(12): pcwrite=1 -> FETCH.
- Latency with zero-wait memory (ack in request cycle): R/addi 4 cycles, lw 5, sw 4, beq/j/nop 3.
- imem_ack/dmem_ack outside FETCH/MEM ignored. Request stays high, outputs stable, while ack low.
- instr must stay stable from DECODE until return to FETCH.
- Exactly one pcwrite pulse per instruction; never asserted with imem_req.

Optional Feature:
CPU5_MCCTRL_ILLEGAL_TRAP_EN: adds output illegal (1 bit). Defined: unknown opcode, or R-type with unmapped funct, goes DECODE -> HALT(13); HALT asserts illegal=1, holds all other outputs at defaults, no pcwrite, leaves only on reset. Undefined: no illegal port; unknown opcode -> NOP, unmapped funct -> ADD.

Test Plan:
- Reset low 3 cycles, release; imem_ack tied 1 -> state IDLE, FETCH next cycle, imem_req=1, instr_we pulse; all selects 0 during reset.
- instr=0x00A64020 (add $8,$5,$6), zero-wait -> FETCH, DECODE, EXEC_R, WB_R; WB_R: regwrite=1, regdst=1, alucontrol=010, pcwrite=1; 4 cycles total.
- lw instr=0x8C850004, dmem_ack delayed 3 cycles -> dmem_req=1, dmem_we=0 held 4 cycles, then WB_L memtoreg=1, regwrite=1; single pcwrite pulse.
- beq instr=0x10A60003 with zero=1, then zero=0 -> BRANCH: alucontrol=110, pcsrc=1 then 0, pcwrite=1 both times; sw 0xAC850008 -> dmem_we=1, no regwrite.
- j instr=0x08000010 -> JUMP jump=1, pcwrite=1; assert reset low during MEM with dmem_req=1 -> dmem_req=0 in same cycle, state=IDLE.
- Opcode 0x3F with CPU5_MCCTRL_ILLEGAL_TRAP_EN -> HALT, illegal=1, pcwrite never pulses; without macro -> NOP, pcwrite pulse, back to FETCH.
